// File: rtl/core_pkg.sv
// Shared encodings for the fetch unit and later pipeline stages:
// next-PC selectors, branch funct3 codes and fetch FSM states.
package core_pkg;

    localparam logic [1:0] NS_SEQ    = 2'd0;
    localparam logic [1:0] NS_BRANCH = 2'd1;
    localparam logic [1:0] NS_JAL    = 2'd2;
    localparam logic [1:0] NS_JALR   = 2'd3;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch resolver: funct3 plus ALU flags -> taken.
// The 010/011 encodings are not branches and never resolve taken.
module branch_cond
    import core_pkg::*;
(
    input  logic [2:0] br_funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (br_funct3)
            F3_BEQ:  taken = zero;
            F3_BNE:  taken = ~zero;
            F3_BLT:  taken = lt;
            F3_BGE:  taken = ~lt;
            F3_BLTU: taken = ltu;
            F3_BGEU: taken = ~ltu;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Multi-cycle PC / instruction-fetch sequencer (IDLE, FETCH, EXEC, HALT).
// Optional PC_TRACE_EN adds simulation-only retire/halt trace output.
module pc_fetch_unit
    import core_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              IALIGN       = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [31:0]     instr,
    output logic            instr_valid,
    input  logic            retire,
    input  logic            stall,
    input  logic [1:0]      next_sel,
    input  logic [2:0]      br_funct3,
    input  logic            zero,
    input  logic            lt,
    input  logic            ltu,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    output logic            misalign,
    output logic [XLEN-1:0] instret,
    output logic [1:0]      state_dbg
);

    // Handshakes: a fetch completes in any cycle where imem_req && imem_gnt
    // (rdata sampled that cycle); an instruction completes in any cycle where
    // instr_valid && retire && !stall. Outside those states gnt/retire are ignored.
    logic [1:0]      state;
    logic            taken;
    logic            accept;
    logic            misaligned;
    logic [XLEN-1:0] pc_imm;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;

    branch_cond u_branch_cond (
        .br_funct3 (br_funct3),
        .zero      (zero),
        .lt        (lt),
        .ltu       (ltu),
        .taken     (taken)
    );

    assign pc_plus4    = pc + XLEN'(4);
    assign pc_imm      = pc + imm;
    assign jalr_sum    = rs1 + imm;
    assign imem_addr   = pc;
    assign imem_req    = (state == ST_FETCH);
    assign instr_valid = (state == ST_EXEC);
    assign state_dbg   = state;
    assign accept      = (state == ST_EXEC) && retire && !stall;

    always_comb begin
        target = pc_plus4;
        case (next_sel)
            NS_SEQ:    target = pc_plus4;
            NS_BRANCH: target = taken ? pc_imm : pc_plus4;
            NS_JAL:    target = pc_imm;
            NS_JALR:   target = {jalr_sum[XLEN-1:1], 1'b0};
            default:   target = pc_plus4;
        endcase
    end

    // IALIGN=2 only needs halfword alignment; anything else is treated as 4.
    assign misaligned = (IALIGN == 2) ? target[0] : (target[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            pc       <= RESET_VECTOR;
            instr    <= '0;
            instret  <= '0;
            misalign <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: state <= ST_FETCH;
                ST_FETCH: begin
                    if (imem_gnt) begin
                        instr <= imem_rdata;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (accept) begin
                        if (misaligned) begin
                            misalign <= 1'b1;
                            state    <= ST_HALT;
                        end else begin
                            pc      <= target;
                            instret <= instret + XLEN'(1);
                            state   <= ST_FETCH;
                        end
                    end
                end
                default: state <= ST_HALT;
            endcase
        end
    end

`ifdef PC_TRACE_EN
    always @(posedge clk) begin
        if (rst_n && accept) begin
            $display("%0t pc=%h instr=%h next_sel=%0d target=%h instret=%0d",
                     $time, pc, instr, next_sel, target, instret);
            if (misaligned)
                $display("%0t HALT: misaligned target %h at pc=%h", $time, target, pc);
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus random traffic, every
// cycle compared against a transaction-level model of the fetch/retire rules.
module tb_pc_fetch_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          imem_req;
    logic [W-1:0]  imem_addr;
    logic          imem_gnt;
    logic [31:0]   imem_rdata;
    logic [W-1:0]  pc;
    logic [W-1:0]  pc_plus4;
    logic [31:0]   instr;
    logic          instr_valid;
    logic          retire;
    logic          stall;
    logic [1:0]    next_sel;
    logic [2:0]    br_funct3;
    logic          zero, lt, ltu;
    logic [W-1:0]  imm;
    logic [W-1:0]  rs1;
    logic          misalign;
    logic [W-1:0]  instret;
    logic [1:0]    state_dbg;

    // ALU operands; the flags are derived from them, the model uses them directly
    logic [W-1:0]  op_a, op_b;
    assign zero = (op_a == op_b);
    assign lt   = ($signed(op_a) < $signed(op_b));
    assign ltu  = (op_a < op_b);

    int total_checks = 0;
    int pass_checks  = 0;
    bit check_en     = 1'b0;

    // model: phase 0 idle, 1 waiting for fetch, 2 holding instr, 3 halted
    int            m_phase;
    logic [W-1:0]  m_pc, m_instret;
    logic [31:0]   m_instr;
    logic          m_mis;

    pc_fetch_unit #(.XLEN(W), .RESET_VECTOR(32'h0), .IALIGN(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rdata  (imem_rdata),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .instr       (instr),
        .instr_valid (instr_valid),
        .retire      (retire),
        .stall       (stall),
        .next_sel    (next_sel),
        .br_funct3   (br_funct3),
        .zero        (zero),
        .lt          (lt),
        .ltu         (ltu),
        .imm         (imm),
        .rs1         (rs1),
        .misalign    (misalign),
        .instret     (instret),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total_checks++;
        if (act === exp) pass_checks++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic bit model_taken(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        case (f)
            3'b000:  return x == y;
            3'b001:  return x != y;
            3'b100:  return $signed(x) < $signed(y);
            3'b101:  return $signed(x) >= $signed(y);
            3'b110:  return x < y;
            3'b111:  return x >= y;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [W-1:0] model_target();
        logic [W-1:0] t;
        case (next_sel)
            2'd1:    t = model_taken(br_funct3, op_a, op_b) ? m_pc + imm : m_pc + 32'd4;
            2'd2:    t = m_pc + imm;
            2'd3:    t = (rs1 + imm) & ~32'd1;
            default: t = m_pc + 32'd4;
        endcase
        return t;
    endfunction

    task automatic model_reset();
        m_phase   = 0;
        m_pc      = '0;
        m_instret = '0;
        m_instr   = '0;
        m_mis     = 1'b0;
    endtask

    always @(posedge clk) begin
        logic [W-1:0] t;
        if (rst_n === 1'b1) begin
            case (m_phase)
                0: m_phase = 1;
                1: if (imem_gnt) begin m_instr = imem_rdata; m_phase = 2; end
                2: if (retire && !stall) begin
                       t = model_target();
                       if (t[1:0] != 2'b00) begin
                           m_mis   = 1'b1;
                           m_phase = 3;
                       end else begin
                           m_pc      = t;
                           m_instret = m_instret + 1;
                           m_phase   = 1;
                       end
                   end
                default: m_phase = 3;
            endcase
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("imem_req",    32'(imem_req),    32'(m_phase == 1));
            chk("instr_valid", 32'(instr_valid), 32'(m_phase == 2));
            chk("pc",          pc,               m_pc);
            chk("imem_addr",   imem_addr,        m_pc);
            chk("pc_plus4",    pc_plus4,         m_pc + 32'd4);
            chk("instr",       instr,            m_instr);
            chk("instret",     instret,          m_instret);
            chk("misalign",    32'(misalign),    32'(m_mis));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_gnt = 0; imem_rdata = '0; retire = 0; stall = 0;
        next_sel = 2'd0; br_funct3 = 3'd0; op_a = '0; op_b = '0; imm = '0; rs1 = '0;
    endtask

    // From a FETCH cycle: grant rdata, then retire it with the given next-PC inputs
    task automatic fetch_exec(input logic [31:0] rd, input logic [1:0] sel, input logic [2:0] f3,
                              input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] im, input logic [W-1:0] r1);
        imem_gnt = 1; imem_rdata = rd;
        step();
        imem_gnt = 0;
        retire = 1; next_sel = sel; br_funct3 = f3; op_a = a; op_b = b; imm = im; rs1 = r1;
        step();
        retire = 0;
    endtask

    task automatic reset_release();
        rst_n = 0;
        model_reset();
        step();
        step();
        rst_n = 1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        model_reset();
        #2;
        chk("reset_pc",      pc,                 32'h0);
        chk("reset_instr",   instr,              32'h0);
        chk("reset_req",     32'(imem_req),      32'h0);
        chk("reset_valid",   32'(instr_valid),   32'h0);
        chk("reset_instret", instret,            32'h0);
        chk("reset_mis",     32'(misalign),      32'h0);
        check_en = 1'b1;
        step();
        rst_n = 1;
        chk("cycle1_req", 32'(imem_req), 32'h0);
        step();
        chk("cycle2_req",  32'(imem_req), 32'h1);
        chk("cycle2_addr", imem_addr,     32'h0);
        imem_gnt = 1; imem_rdata = 32'h0050_0093;
        step();
        imem_gnt = 0;
        chk("first_valid", 32'(instr_valid), 32'h1);
        chk("first_instr", instr,            32'h0050_0093);
        retire = 1; next_sel = 2'd0;
        step();
        retire = 0;
        chk("seq_pc",      pc,               32'h4);
        chk("seq_instret", instret,          32'h1);
        chk("seq_valid",   32'(instr_valid), 32'h0);
        chk("seq_req",     32'(imem_req),    32'h1);

        fetch_exec(32'h1, 2'd0, 3'd0, 0, 0, 0, 0);
        chk("at_8", pc, 32'h8);
        fetch_exec(32'h2, 2'd1, 3'b000, 5, 5, 32'hFFFF_FFF8, 0);
        chk("beq_taken", pc, 32'h0);
        fetch_exec(32'h3, 2'd0, 3'd0, 0, 0, 0, 0);
        fetch_exec(32'h4, 2'd0, 3'd0, 0, 0, 0, 0);
        fetch_exec(32'h5, 2'd1, 3'b001, 5, 5, 32'hFFFF_FFF8, 0);
        chk("bne_not_taken", pc, 32'hC);
        fetch_exec(32'h6, 2'd3, 3'd0, 0, 0, 32'h0, 32'h8);
        fetch_exec(32'h7, 2'd1, 3'b110, 1, 2, 32'hFFFF_FFF8, 0);
        chk("bltu_taken", pc, 32'h0);
        fetch_exec(32'h8, 2'd3, 3'd0, 0, 0, 32'h4, 32'h101);
        chk("jalr_pc", pc, 32'h104);

        imem_gnt = 1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_gnt = 0;
        retire = 1; stall = 1; next_sel = 2'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc",    pc,      32'h104);
            chk("stall_instr", instr,   32'hDEAD_BEEF);
            chk("stall_ret",   instret, 32'd9);
        end
        stall = 0;
        step();
        retire = 0;
        chk("unstall_pc",  pc,      32'h108);
        chk("unstall_ret", instret, 32'd10);

        fetch_exec(32'h9, 2'd2, 3'd0, 0, 0, 32'h6, 0);
        chk("jal_mis",     32'(misalign), 32'h1);
        chk("jal_pc",      pc,            32'h108);
        chk("jal_instret", instret,       32'd10);
        for (int i = 0; i < 3; i++) begin
            imem_gnt = 1; retire = 1;
            step();
            chk("halt_req", 32'(imem_req), 32'h0);
        end
        idle_inputs();

        reset_release();
        step();
        fetch_exec(32'hA, 2'd0, 3'd0, 0, 0, 0, 0);
        step();
        #2;
        rst_n = 0;
        model_reset();
        #1;
        chk("async_pc",  pc,            32'h0);
        chk("async_req", 32'(imem_req), 32'h0);
        chk("async_ret", instret,       32'h0);
        step();
        rst_n = 1;

        for (int c = 0; c < 3000; c++) begin
            imem_gnt   = ($urandom_range(0, 2) != 0);
            imem_rdata = $urandom;
            retire     = $urandom_range(0, 1);
            stall      = ($urandom_range(0, 3) == 0);
            next_sel   = 2'($urandom_range(0, 3));
            br_funct3  = 3'($urandom_range(0, 7));
            op_a       = $urandom_range(0, 15);
            op_b       = ($urandom_range(0, 3) == 0) ? op_a : $urandom;
            imm        = $urandom;
            if ($urandom_range(0, 9) != 0) imm = imm & ~32'd3;
            rs1        = $urandom;
            if ($urandom_range(0, 4) != 0) rs1 = rs1 & ~32'd3;
            if (m_phase == 3 && $urandom_range(0, 3) == 0) begin
                rst_n = 0;
                model_reset();
                step();
                rst_n = 1;
            end else begin
                step();
            end
        end

        check_en = 1'b0;
        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Parametrised program-counter and instruction-fetch sequencer for the next-generation RISC-V core. Replaces the single-cycle PC register with a multi-cycle FETCH/EXEC state machine. Fetches through a request/grant instruction-memory port and holds the fetched instruction for the core. Computes the next PC for sequential flow, all six conditional branches, JAL and JALR, with stall support, misaligned-target trapping and a retired-instruction counter.

## Interface
Parameters:
- XLEN, 32, address/data width of PC, immediate, rs1 and instret.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- IALIGN, 4, instruction alignment in bytes; only 4 or 2 are legal.

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request; high only in FETCH.
- imem_addr  out  XLEN  fetch address; always equals pc.
- imem_gnt  in  1  memory grant; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- pc  out  XLEN  current PC.
- pc_plus4  out  XLEN  pc+4 modulo 2^XLEN, used as the link value.
- instr  out  32  latched instruction.
- instr_valid  out  1  instr is valid; high only in EXEC.
- retire  in  1  core completes instr this cycle; next-PC inputs are sampled this cycle.
- stall  in  1  freezes the unit; has priority over retire.
- next_sel  in  2  next-PC source: 0 SEQ, 1 BRANCH, 2 JAL, 3 JALR.
- br_funct3  in  3  branch condition (instr[14:12]).
- zero, lt, ltu  in  1 each  ALU flags: equal, signed less-than, unsigned less-than.
- imm  in  XLEN  sign-extended immediate.
- rs1  in  XLEN  rs1 value, used for JALR.
- misalign  out  1  sticky flag: a misaligned target was detected.
- instret  out  XLEN  retired-instruction count, wraps modulo 2^XLEN.

## Operation
- States: IDLE, FETCH, EXEC, HALT. Reset enters IDLE.
- IDLE -> FETCH unconditionally on the next clock.
- FETCH: imem_req=1. On imem_gnt, latch imem_rdata into instr and go to EXEC. With no grant, stay in FETCH for an unbounded wait.
- EXEC: instr_valid=1.
  - stall=1: hold everything, whatever retire is.
  - retire=1 and stall=0: compute target. If the target is aligned, load it into pc, increment instret and go to FETCH. If the target is misaligned, set misalign=1, leave pc unchanged, leave instret unchanged and go to HALT.
- HALT: all requests deasserted. Left only by reset.
- Target per next_sel:
  - SEQ: pc+4.
  - BRANCH: pc+imm if taken, otherwise pc+4.
  - JAL: pc+imm.
  - JALR: (rs1+imm) with bit 0 cleared.
- Branch taken per br_funct3: 000 zero; 001 !zero; 100 lt; 101 !lt; 110 ltu; 111 !ltu; 010, 011 never taken.
- Misaligned test: target[1:0]!=0 when IALIGN=4; target[0]!=0 when IALIGN=2. A not-taken branch checks pc+4.
- All adds are XLEN-bit and wrap with no overflow detection.
- retire outside EXEC is ignored. imem_gnt outside FETCH is ignored.

## Timing
- Reset (async, immediate): state=IDLE, pc=RESET_VECTOR, instr=0, instr_valid=0, imem_req=0, misalign=0, instret=0.
- imem_req and instr_valid are decoded from registered state, so they are glitch-free and change one cycle after a transition.
- Minimum 2 cycles per instruction: a FETCH cycle with grant, then an EXEC cycle with retire.
- First imem_req is in the 2nd cycle after rst_n deasserts.
- pc, instr, instret and misalign update on the clock edge that ends the qualifying cycle.
- Reset asserted mid-FETCH or mid-EXEC aborts immediately; a pending grant is discarded.

## Configuration
- PC_TRACE_EN defined: on every accepted retire edge, $display the time, pc, instr, next_sel, target and instret. Also display a one-line message on entry to HALT.
- PC_TRACE_EN undefined: no display statements. Synthesised logic is identical in both builds.

## Structure
- Shared package core_pkg holds:
  - next_sel encodings NS_SEQ, NS_BRANCH, NS_JAL, NS_JALR;
  - branch funct3 constants F3_BEQ through F3_BGEU;
  - FSM state encodings.
- One sub-module, branch_cond: purely combinational, maps br_funct3, zero, lt and ltu to taken. It is reused later by the pipelined core.

## Test plan
- Reset then idle: release rst_n. Cycle 1 shows imem_req=0. Cycle 2 shows imem_req=1 with imem_addr=0x0. Grant with rdata=0x00500093 -> next cycle instr_valid=1 and instr=0x00500093.
- Sequential: retire with SEQ at pc=0x0 -> pc=0x4, instret=1, instr_valid=0, imem_req=1.
- Branches at pc=0x8 with imm=0xFFFFFFF8:
  - BEQ with zero=1 -> pc=0x0.
  - BNE with zero=1 -> pc=0xC.
  - BLTU with ltu=1 -> pc=0x0.
- Jumps:
  - JALR with rs1=0x101, imm=0x4 -> pc=0x104.
  - JAL with imm=0x6, IALIGN=4 -> misalign=1, HALT, pc unchanged, imem_req stays 0.
- Stall priority: retire=1 and stall=1 held for 3 cycles -> pc, instret and instr unchanged. Then retire alone -> pc advances by 4.
- Reset mid-fetch: assert rst_n low while in FETCH with no grant -> outputs take reset values immediately, with no clock edge needed.
